// File: rtl/pad_seq_pkg.sv
// Shared types and constants for the pad mux sequencer: FSM states, field
// widths and the latched request record.
package pad_seq_pkg;

    localparam int PAD_CFG_W     = 6;
    localparam int PAD_MUX_W     = 2;
    localparam int PAD_IDX_W     = 6;
    localparam int NPADS_DEFAULT = 48;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } pad_seq_state_e;

    typedef struct packed {
        logic [PAD_IDX_W-1:0] pad;
        logic [PAD_MUX_W-1:0] mux;
        logic [PAD_CFG_W-1:0] cfg;
    } pad_req_t;

endpackage

// File: rtl/pad_seq_timer.sv
// Loadable 8-bit down-counter; done is high whenever the count has reached zero.
module pad_seq_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 8'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/pad_mux_sequencer.sv
// Owns per-pad cfg/mux state and applies single-pad updates as
// isolate -> apply -> settle -> release, reporting completion with a pulse.
module pad_mux_sequencer
    import pad_seq_pkg::*;
#(
    parameter int NPADS        = NPADS_DEFAULT,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // valid/ready: a request transfers on any cycle where both are high;
    // ready depends on state only, never on valid.
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [5:0]             req_pad_i,
    input  logic [1:0]             req_mux_i,
    input  logic [5:0]             req_cfg_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [NPADS*6-1:0]     pad_cfg_o,
    output logic [NPADS*2-1:0]     pad_mux_o,
    output logic [NPADS-1:0]       pad_oe_mask_o,
    output logic [2:0]             dbg_state_o
);

    localparam logic [6:0] NPADS_LIM   = 7'(NPADS);
    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);

    pad_seq_state_e state_q, state_d;
    pad_req_t       req_q;

    logic [NPADS-1:0][PAD_CFG_W-1:0] cfg_q;
    logic [NPADS-1:0][PAD_MUX_W-1:0] mux_q;
    logic [NPADS-1:0]                mask_q;
    logic                            rsp_valid_q;
    logic                            rsp_err_q;

    logic accept;
    logic in_range;
    logic is_noop;
    logic timer_load;
    logic timer_done;

    assign accept   = req_valid_i && (state_q == ST_IDLE);
    assign in_range = ({1'b0, req_pad_i} < NPADS_LIM);

    // Loop-based lookup keeps out-of-range indices from reading past the arrays.
    always_comb begin
        is_noop = 1'b0;
        for (int i = 0; i < NPADS; i++) begin
            if (req_pad_i == 6'(i)) begin
                is_noop = (cfg_q[i] == req_cfg_i) && (mux_q[i] == req_mux_i);
            end
        end
    end

    assign timer_load = accept || (state_q == ST_APPLY);

    pad_seq_timer u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (timer_load),
        .load_val_i (GUARD_LOAD),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = (!in_range || is_noop) ? ST_DONE : ST_ISOLATE;
            ST_ISOLATE: if (timer_done) state_d = ST_APPLY;
            ST_APPLY:   state_d = ST_SETTLE;
            ST_SETTLE:  if (timer_done) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cfg_q       <= '0;
            mux_q       <= '0;
            mask_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == ST_DONE);
            // Only the direct IDLE->DONE path can carry an error.
            rsp_err_q   <= accept && !in_range;
            if (accept) begin
                req_q <= '{pad: req_pad_i, mux: req_mux_i, cfg: req_cfg_i};
            end
            for (int i = 0; i < NPADS; i++) begin
                if (accept && in_range && !is_noop && req_pad_i == 6'(i)) begin
                    mask_q[i] <= 1'b0;
                end
                if (state_q == ST_APPLY && req_q.pad == 6'(i)) begin
                    cfg_q[i] <= req_q.cfg;
                    mux_q[i] <= req_q.mux;
                end
                if (state_q == ST_SETTLE && timer_done && req_q.pad == 6'(i)) begin
                    mask_q[i] <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = ~req_ready_o;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign pad_cfg_o     = cfg_q;
    assign pad_mux_o     = mux_q;
    assign pad_oe_mask_o = mask_q;
    assign dbg_state_o   = state_q;

endmodule
